// File: rtl/plic_pkg.sv
// Shared constants and FSM encoding for the PLIC context responder.
package plic_pkg;

  localparam int unsigned IdWDefault = 5;
  localparam int unsigned IdReserved = 0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StInsvc = 2'd2,
    StCplt  = 2'd3
  } plic_state_e;

endpackage

// File: rtl/plic_ctx_resp_if.sv
// Signal bundle between PLIC, pipeline/CSR side and the context responder.
interface plic_ctx_resp_if #(
  parameter int unsigned ID_W = plic_pkg::IdWDefault
) ();

  logic            core_ex_trap_valid_i;
  logic [ID_W-1:0] core_ex_trap_id_i;
  logic            core_ex_trap_ready_o;
  logic            core_ex_trap_cplet_o;
  logic [ID_W-1:0] core_ex_trap_cplet_id_o;
  logic            meie_i;
  logic            trap_req_o;
  logic [ID_W-1:0] trap_id_o;
  logic            trap_ack_i;
  logic            cplt_req_i;
  logic [ID_W-1:0] cplt_id_i;
  logic            busy_o;
  logic            cplt_err_o;

  // Driving side (PLIC + pipeline + CSR file)
  modport master (
    output core_ex_trap_valid_i, core_ex_trap_id_i, meie_i, trap_ack_i, cplt_req_i, cplt_id_i,
    input  core_ex_trap_ready_o, core_ex_trap_cplet_o, core_ex_trap_cplet_id_o, trap_req_o,
           trap_id_o, busy_o, cplt_err_o
  );

  // Responder side
  modport slave (
    input  core_ex_trap_valid_i, core_ex_trap_id_i, meie_i, trap_ack_i, cplt_req_i, cplt_id_i,
    output core_ex_trap_ready_o, core_ex_trap_cplet_o, core_ex_trap_cplet_id_o, trap_req_o,
           trap_id_o, busy_o, cplt_err_o
  );

endinterface

// File: rtl/plic_ctx_resp.sv
// Per-hart PLIC context responder: claim, trap request, service and completion handshake.
// Single outstanding claim; every output comes straight from a register.
module plic_ctx_resp
  import plic_pkg::*;
#(
  parameter int unsigned ID_W = IdWDefault
) (
  input logic           clk,
  input logic           rst,
  plic_ctx_resp_if.slave bus
);

  plic_state_e     state_q, state_d;
  logic [ID_W-1:0] claim_q, claim_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic            trap_req_q, busy_q, cplet_q;
  logic [ID_W-1:0] cplet_id_q;

  always_comb begin
    state_d = state_q;
    claim_d = claim_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.core_ex_trap_valid_i && bus.meie_i &&
            (bus.core_ex_trap_id_i != ID_W'(IdReserved))) begin
          state_d = StReq;
          claim_d = bus.core_ex_trap_id_i;
          ready_d = 1'b1;
        end
        err_d = bus.cplt_req_i;
      end
      StReq: begin
        // The request is not withdrawn on a meie drop; a completion here is always illegal.
        if (bus.trap_ack_i) state_d = StInsvc;
        err_d = bus.cplt_req_i;
      end
      StInsvc: begin
        if (bus.cplt_req_i) begin
          if (bus.cplt_id_i == claim_q) state_d = StCplt;
          else                          err_d   = 1'b1;
        end
      end
      StCplt: begin
        state_d = StIdle;
        err_d   = bus.cplt_req_i;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      claim_q    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      trap_req_q <= 1'b0;
      busy_q     <= 1'b0;
      cplet_q    <= 1'b0;
      cplet_id_q <= '0;
    end else begin
      state_q    <= state_d;
      claim_q    <= claim_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      trap_req_q <= (state_d == StReq);
      busy_q     <= (state_d != StIdle);
      cplet_q    <= (state_d == StCplt);
      cplet_id_q <= (state_d == StCplt) ? claim_d : '0;
    end
  end

  assign bus.core_ex_trap_ready_o    = ready_q;
  assign bus.core_ex_trap_cplet_o    = cplet_q;
  assign bus.core_ex_trap_cplet_id_o = cplet_id_q;
  assign bus.trap_req_o              = trap_req_q;
  assign bus.trap_id_o               = claim_q;
  assign bus.busy_o                  = busy_q;
  assign bus.cplt_err_o              = err_q;

endmodule

// File: tb/tb_plic_ctx_resp.sv
// Directed self-checking bench for plic_ctx_resp.
module tb_plic_ctx_resp;

  localparam int unsigned IdW = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  plic_ctx_resp_if #(.ID_W(IdW)) intf ();

  plic_ctx_resp #(.ID_W(IdW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One active edge, then return at the following falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    intf.core_ex_trap_valid_i = 1'b0;
    intf.core_ex_trap_id_i    = '0;
    intf.meie_i               = 1'b0;
    intf.trap_ack_i           = 1'b0;
    intf.cplt_req_i           = 1'b0;
    intf.cplt_id_i            = '0;
    @(negedge clk);
    step();
    step();
    check("rst_ready",    32'(intf.core_ex_trap_ready_o), 32'd0);
    check("rst_cplet",    32'(intf.core_ex_trap_cplet_o), 32'd0);
    check("rst_cplet_id", 32'(intf.core_ex_trap_cplet_id_o), 32'd0);
    check("rst_trap_req", 32'(intf.trap_req_o), 32'd0);
    check("rst_trap_id",  32'(intf.trap_id_o), 32'd0);
    check("rst_busy",     32'(intf.busy_o), 32'd0);
    check("rst_err",      32'(intf.cplt_err_o), 32'd0);
    rst = 1'b0;
    step();

    // Basic flow with id 5, including a meie drop while the request is pending
    intf.meie_i = 1'b1;
    intf.core_ex_trap_valid_i = 1'b1;
    intf.core_ex_trap_id_i = 5'd5;
    step();
    check("basic_ready",    32'(intf.core_ex_trap_ready_o), 32'd1);
    check("basic_trap_req", 32'(intf.trap_req_o), 32'd1);
    check("basic_trap_id",  32'(intf.trap_id_o), 32'd5);
    check("basic_busy",     32'(intf.busy_o), 32'd1);
    intf.core_ex_trap_valid_i = 1'b0;
    intf.meie_i = 1'b0;
    step();
    check("basic_ready_1cyc",   32'(intf.core_ex_trap_ready_o), 32'd0);
    check("basic_req_held",     32'(intf.trap_req_o), 32'd1);
    intf.meie_i = 1'b1;
    intf.trap_ack_i = 1'b1;
    step();
    intf.trap_ack_i = 1'b0;
    check("basic_ack_req",  32'(intf.trap_req_o), 32'd0);
    check("basic_ack_busy", 32'(intf.busy_o), 32'd1);
    intf.cplt_req_i = 1'b1;
    intf.cplt_id_i = 5'd5;
    step();
    intf.cplt_req_i = 1'b0;
    check("basic_cplet",    32'(intf.core_ex_trap_cplet_o), 32'd1);
    check("basic_cplet_id", 32'(intf.core_ex_trap_cplet_id_o), 32'd5);
    check("basic_cplt_err", 32'(intf.cplt_err_o), 32'd0);
    step();
    check("basic_cplet_end", 32'(intf.core_ex_trap_cplet_o), 32'd0);
    check("basic_idle_busy", 32'(intf.busy_o), 32'd0);

    // Masked request held for 10 cycles, then unmasked
    intf.meie_i = 1'b0;
    intf.core_ex_trap_valid_i = 1'b1;
    intf.core_ex_trap_id_i = 5'd3;
    for (int i = 0; i < 10; i++) begin
      step();
      check("mask_ready",    32'(intf.core_ex_trap_ready_o), 32'd0);
      check("mask_trap_req", 32'(intf.trap_req_o), 32'd0);
    end
    intf.meie_i = 1'b1;
    step();
    intf.core_ex_trap_valid_i = 1'b0;
    check("unmask_ready",   32'(intf.core_ex_trap_ready_o), 32'd1);
    check("unmask_trap_id", 32'(intf.trap_id_o), 32'd3);
    intf.trap_ack_i = 1'b1;
    step();
    intf.trap_ack_i = 1'b0;
    intf.cplt_req_i = 1'b1;
    intf.cplt_id_i = 5'd3;
    step();
    intf.cplt_req_i = 1'b0;
    check("unmask_cplet_id", 32'(intf.core_ex_trap_cplet_id_o), 32'd3);
    step();
    check("unmask_idle", 32'(intf.busy_o), 32'd0);

    // Bad completion in service with claim 7
    intf.core_ex_trap_valid_i = 1'b1;
    intf.core_ex_trap_id_i = 5'd7;
    step();
    intf.core_ex_trap_valid_i = 1'b0;
    intf.trap_ack_i = 1'b1;
    step();
    intf.trap_ack_i = 1'b0;
    intf.cplt_req_i = 1'b1;
    intf.cplt_id_i = 5'd6;
    step();
    intf.cplt_req_i = 1'b0;
    check("bad_err",   32'(intf.cplt_err_o), 32'd1);
    check("bad_cplet", 32'(intf.core_ex_trap_cplet_o), 32'd0);
    check("bad_busy",  32'(intf.busy_o), 32'd1);
    step();
    check("bad_err_pulse", 32'(intf.cplt_err_o), 32'd0);
    check("bad_held_busy", 32'(intf.busy_o), 32'd1);
    check("bad_held_id",   32'(intf.trap_id_o), 32'd7);
    intf.cplt_req_i = 1'b1;
    intf.cplt_id_i = 5'd7;
    step();
    intf.cplt_req_i = 1'b0;
    check("good_cplet",    32'(intf.core_ex_trap_cplet_o), 32'd1);
    check("good_cplet_id", 32'(intf.core_ex_trap_cplet_id_o), 32'd7);
    step();

    // Reset during service with claim 9
    intf.core_ex_trap_valid_i = 1'b1;
    intf.core_ex_trap_id_i = 5'd9;
    step();
    intf.core_ex_trap_valid_i = 1'b0;
    intf.trap_ack_i = 1'b1;
    step();
    intf.trap_ack_i = 1'b0;
    check("mid_busy", 32'(intf.busy_o), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy",     32'(intf.busy_o), 32'd0);
    check("mid_rst_trap_id",  32'(intf.trap_id_o), 32'd0);
    check("mid_rst_cplet",    32'(intf.core_ex_trap_cplet_o), 32'd0);
    check("mid_rst_trap_req", 32'(intf.trap_req_o), 32'd0);
    step();
    check("mid_rst_no_cplet", 32'(intf.core_ex_trap_cplet_o), 32'd0);

    // Reserved id 0, then overlapping valid during service
    intf.core_ex_trap_valid_i = 1'b1;
    intf.core_ex_trap_id_i = 5'd0;
    step();
    check("rsvd_ready", 32'(intf.core_ex_trap_ready_o), 32'd0);
    check("rsvd_busy",  32'(intf.busy_o), 32'd0);
    intf.core_ex_trap_id_i = 5'd2;
    step();
    check("ovl_claim2", 32'(intf.core_ex_trap_ready_o), 32'd1);
    intf.core_ex_trap_valid_i = 1'b0;
    intf.trap_ack_i = 1'b1;
    step();
    intf.trap_ack_i = 1'b0;
    intf.core_ex_trap_valid_i = 1'b1;
    intf.core_ex_trap_id_i = 5'd4;
    step();
    check("ovl_ready_insvc", 32'(intf.core_ex_trap_ready_o), 32'd0);
    check("ovl_trap_id",     32'(intf.trap_id_o), 32'd2);
    intf.cplt_req_i = 1'b1;
    intf.cplt_id_i = 5'd2;
    step();
    intf.cplt_req_i = 1'b0;
    check("ovl_cplet_id",    32'(intf.core_ex_trap_cplet_id_o), 32'd2);
    check("ovl_ready_cplt",  32'(intf.core_ex_trap_ready_o), 32'd0);
    step();
    check("ovl_ready_idle0", 32'(intf.core_ex_trap_ready_o), 32'd0);
    check("ovl_busy_idle0",  32'(intf.busy_o), 32'd0);
    step();
    intf.core_ex_trap_valid_i = 1'b0;
    check("ovl_claim4_ready", 32'(intf.core_ex_trap_ready_o), 32'd1);
    check("ovl_claim4_id",    32'(intf.trap_id_o), 32'd4);

    // Simultaneous ack and completion in REQ: ack wins, completion flagged
    intf.trap_ack_i = 1'b1;
    intf.cplt_req_i = 1'b1;
    intf.cplt_id_i = 5'd4;
    step();
    intf.trap_ack_i = 1'b0;
    intf.cplt_req_i = 1'b0;
    check("sim_err",      32'(intf.cplt_err_o), 32'd1);
    check("sim_trap_req", 32'(intf.trap_req_o), 32'd0);
    check("sim_cplet",    32'(intf.core_ex_trap_cplet_o), 32'd0);
    check("sim_busy",     32'(intf.busy_o), 32'd1);
    intf.cplt_req_i = 1'b1;
    step();
    intf.cplt_req_i = 1'b0;
    check("sim_cplet_id", 32'(intf.core_ex_trap_cplet_id_o), 32'd4);
    step();

    // Completion strobe while idle
    intf.cplt_req_i = 1'b1;
    intf.cplt_id_i = 5'd4;
    step();
    intf.cplt_req_i = 1'b0;
    check("idle_cplt_err",  32'(intf.cplt_err_o), 32'd1);
    check("idle_cplt_busy", 32'(intf.busy_o), 32'd0);
    check("idle_cplt_cplet", 32'(intf.core_ex_trap_cplet_o), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
